// File: rtl/f_stage_pc.sv
// Fetch-stage PC unit: holds the fetch PC, selects the next PC (reset, exception
// entry, eret, branch/jump, sequential) and flags AdEL on illegal fetch addresses.
module f_stage_pc #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] PC_HANDLER = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        en,
  input  logic        bj_D,
  input  logic        taken_D,
  input  logic [31:0] target_D,
  input  logic        eret_D,
  input  logic [31:0] EPC,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_F,
  output logic [4:0]  ExcCode_F,
  output logic        bd_F
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc;
  logic [31:0] npc;
  logic        adel;

  always_ff @(posedge clk) begin
    if (reset)     pc <= PC_RESET;
    else if (Req)  pc <= PC_HANDLER;
    else if (en)   pc <= npc;
  end

  // eret outranks a taken branch; PC+4 wraps modulo 2^32
  always_comb begin
    npc = pc + 32'd4;
    if (eret_D)       npc = EPC;
    else if (taken_D) npc = target_D;
  end

  assign adel = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

  // eret has no delay slot: the F slot is squashed to a nop, hiding any AdEL
  always_comb begin
    Instr_F   = i_inst_rdata;
    ExcCode_F = '0;
    if (eret_D) begin
      Instr_F = '0;
    end else if (adel) begin
      Instr_F   = '0;
      ExcCode_F = EXC_ADEL;
    end
  end

  assign bd_F        = bj_D & ~eret_D;
  assign PC_F        = pc;
  assign i_inst_addr = pc;

endmodule

// File: tb/tb_f_stage_pc.sv
// Table-driven bench for f_stage_pc: each row drives one cycle of inputs and names
// the PC expected during that cycle; the remaining outputs come from a scoreboard.
module tb_f_stage_pc;

  logic        clk = 1'b0;
  logic        reset, Req, en, bj_D, taken_D, eret_D;
  logic [31:0] target_D, EPC, i_inst_addr, i_inst_rdata, PC_F, Instr_F;
  logic [4:0]  ExcCode_F;
  logic        bd_F;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  f_stage_pc #(
    .PC_RESET  (32'h0000_3000),
    .PC_HANDLER(32'h0000_4180),
    .IM_LO     (32'h0000_3000),
    .IM_HI     (32'h0000_6FFC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Req         (Req),
    .en          (en),
    .bj_D        (bj_D),
    .taken_D     (taken_D),
    .target_D    (target_D),
    .eret_D      (eret_D),
    .EPC         (EPC),
    .i_inst_addr (i_inst_addr),
    .i_inst_rdata(i_inst_rdata),
    .PC_F        (PC_F),
    .Instr_F     (Instr_F),
    .ExcCode_F   (ExcCode_F),
    .bd_F        (bd_F)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  // Combinational instruction memory, tolerant of any address
  assign i_inst_rdata = mem(i_inst_addr);

  typedef struct {
    logic        rst, req, en, bj, taken, eret;
    logic [31:0] tgt, epc, pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc, instr;
    logic [4:0]  exc;
    logic        bd;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic rst, req, en_i, bj, taken, eret,
                              input logic [31:0] tgt, epc, pc);
    vec_t v;
    v.rst = rst; v.req = req; v.en = en_i; v.bj = bj; v.taken = taken;
    v.eret = eret; v.tgt = tgt; v.epc = epc; v.pc = pc;
    return v;
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t e;
    logic illegal;
    illegal = (v.pc[1:0] != 2'b00) || (v.pc < 32'h3000) || (v.pc > 32'h6FFC);
    e.pc    = v.pc;
    e.bd    = v.bj && !v.eret;
    e.instr = (v.eret || illegal) ? 32'd0 : mem(v.pc);
    e.exc   = (!v.eret && illegal) ? 5'd4 : 5'd0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    reset = v.rst; Req = v.req; en = v.en; bj_D = v.bj; taken_D = v.taken;
    eret_D = v.eret; target_D = v.tgt; EPC = v.epc;
    exp_q.push_back(model(v));
    #2;
    e = exp_q.pop_front();
    check($sformatf("row%0d PC_F", idx), PC_F, e.pc);
    check($sformatf("row%0d i_inst_addr", idx), i_inst_addr, e.pc);
    check($sformatf("row%0d Instr_F", idx), Instr_F, e.instr);
    check($sformatf("row%0d ExcCode_F", idx), {27'd0, ExcCode_F}, {27'd0, e.exc});
    check($sformatf("row%0d bd_F", idx), {31'd0, bd_F}, {31'd0, e.bd});
  endtask

  initial begin
    //            rst req en bj tk er  target         epc            expected PC
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0000_3000));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0000_3004));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h0000_3100, 32'h0,         32'h0000_3008));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0000_3100));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h0000_3010, 32'h0,         32'h0000_3104));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0000_3200, 32'h0,         32'h0000_3010));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0000_3200, 32'h0,         32'h0000_3010));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0000_3200, 32'h0,         32'h0000_3010));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h0000_3200, 32'h0,         32'h0000_3010));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 32'h0,         32'h0000_3024, 32'h0000_3200));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h0,         32'h0000_3024, 32'h0000_3024));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h0000_3002, 32'h0,         32'h0000_4180));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h0000_7000, 32'h0,         32'h0000_3002));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h0000_6FFC, 32'h0,         32'h0000_7000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_6FFC));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0000_4180));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'hFFFF_FFFC, 32'h0,         32'h0000_4184));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h0000_2FFC, 32'h0,         32'h0000_0000));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0000_2FFC));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 32'h0000_3300, 32'h0000_3040, 32'h0000_3000));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'h0,         32'h0000_7001, 32'h0000_3040));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_7001));

    reset = 1'b1; Req = 1'b0; en = 1'b0; bj_D = 1'b0; taken_D = 1'b0;
    eret_D = 1'b0; target_D = '0; EPC = '0;
    repeat (2) @(posedge clk);

    for (int unsigned i = 0; i < tbl.size(); i++) apply(tbl[i], int'(i));

    // Reset mid-stall together with Req: reset wins, no residual state
    apply(mk(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_7001), 100);
    apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_3000), 101);
    apply(mk(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0000_3000), 102);
    apply(mk(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0000_3004), 103);

    // Req while stalled mid-branch: handler entry regardless of en and taken_D
    apply(mk(0, 1, 0, 1, 1, 0, 32'h0000_3500, 32'h0, 32'h0000_3008), 110);
    apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_4180), 111);

    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
